// File: rtl/usb_tx_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI and EOP generation onto D+/D-.
// Paces the upstream shifter with a one-cycle shift_strobe per consumed data bit.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_active,
  input  logic serial_in,
  input  logic eop,
  output logic shift_strobe,
  output logic stuffing,
  output logic d_plus,
  output logic d_minus,
  output logic tx_done
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LIMIT);

  typedef enum logic [2:0] {IDLE, DATA, STUFF, SE0_1, SE0_2, EOP_J} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [ONES_W-1:0]  ones_inc;
  logic               level_q, level_d;
  logic               d_plus_q, d_plus_d;
  logic               d_minus_q, d_minus_d;
  logic               stuffing_q, stuffing_d;
  logic               tx_done_q, tx_done_d;
  logic               boundary;
  logic               data_level;

  assign boundary = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign ones_inc = ones_q + ONES_W'(1);

  // level_q is the NRZI line level, 1 = J
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    ones_d       = ones_q;
    level_d      = level_q;
    d_plus_d     = d_plus_q;
    d_minus_d    = d_minus_q;
    stuffing_d   = stuffing_q;
    tx_done_d    = 1'b0;
    shift_strobe = 1'b0;
    data_level   = serial_in ? level_q : ~level_q;

    if ((state_q == DATA || state_q == STUFF) && !tx_active) begin
      // Abort is honoured on any cycle of a packet, not just at a boundary
      state_d    = IDLE;
      cnt_d      = '0;
      ones_d     = '0;
      level_d    = 1'b1;
      d_plus_d   = 1'b1;
      d_minus_d  = 1'b0;
      stuffing_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d      = '0;
          ones_d     = '0;
          level_d    = 1'b1;
          d_plus_d   = 1'b1;
          d_minus_d  = 1'b0;
          stuffing_d = 1'b0;
          if (tx_active) state_d = DATA;
        end
        DATA: begin
          if (boundary) begin
            stuffing_d = 1'b0;
            if (eop) begin
              state_d   = SE0_1;
              d_plus_d  = 1'b0;
              d_minus_d = 1'b0;
            end else begin
              shift_strobe = 1'b1;
              level_d      = data_level;
              d_plus_d     = data_level;
              d_minus_d    = ~data_level;
              ones_d       = serial_in ? ones_inc : '0;
              if (serial_in && ones_inc == ONES_STUFF) state_d = STUFF;
            end
          end
        end
        STUFF: begin
          if (boundary) begin
            level_d    = ~level_q;
            d_plus_d   = ~level_q;
            d_minus_d  = level_q;
            ones_d     = '0;
            stuffing_d = 1'b1;
            state_d    = DATA;
          end
        end
        SE0_1: begin
          if (boundary) state_d = SE0_2;
        end
        SE0_2: begin
          if (boundary) begin
            state_d   = EOP_J;
            level_d   = 1'b1;
            d_plus_d  = 1'b1;
            d_minus_d = 1'b0;
          end
        end
        EOP_J: begin
          if (boundary) begin
            tx_done_d = 1'b1;
            ones_d    = '0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      level_q    <= 1'b1;
      d_plus_q   <= 1'b1;
      d_minus_q  <= 1'b0;
      stuffing_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      level_q    <= level_d;
      d_plus_q   <= d_plus_d;
      d_minus_q  <= d_minus_d;
      stuffing_q <= stuffing_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign d_plus   = d_plus_q;
  assign d_minus  = d_minus_q;
  assign stuffing = stuffing_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: per-cycle comparison of the bus against a
// symbol-level USB line model (NRZI + stuffing + EOP), fed by a model shifter.
module tb_usb_tx_encoder;

  localparam int CPB   = 8;
  localparam int LIMIT = 6;

  logic clk = 1'b0;
  logic n_rst, tx_active, serial_in, eop;
  logic shift_strobe, stuffing, d_plus, d_minus, tx_done;

  int checks = 0;
  int errors = 0;

  bit pkt_q[$];
  bit sym_dp[$], sym_dm[$], sym_st[$], sym_dat[$];

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(LIMIT)) dut (
    .clk(clk), .n_rst(n_rst), .tx_active(tx_active), .serial_in(serial_in),
    .eop(eop), .shift_strobe(shift_strobe), .stuffing(stuffing),
    .d_plus(d_plus), .d_minus(d_minus), .tx_done(tx_done)
  );

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pkt_q.push_back(b[i]);
  endfunction

  function automatic void push_sym(input bit dp, input bit dm, input bit st, input bit dat);
    sym_dp.push_back(dp); sym_dm.push_back(dm); sym_st.push_back(st); sym_dat.push_back(dat);
  endfunction

  // One entry per bus bit period: idle J lead-in, encoded data, stuffs, SE0 SE0 J
  function automatic void build_model();
    bit level = 1'b1;
    int ones  = 0;
    sym_dp.delete(); sym_dm.delete(); sym_st.delete(); sym_dat.delete();
    push_sym(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (pkt_q[i]) begin
      if (pkt_q[i]) ones++;
      else begin level = !level; ones = 0; end
      push_sym(level, !level, 1'b0, 1'b1);
      if (ones == LIMIT) begin
        level = !level; ones = 0;
        push_sym(level, !level, 1'b1, 1'b0);
      end
    end
    push_sym(1'b0, 1'b0, 1'b0, 1'b0);
    push_sym(1'b0, 1'b0, 1'b0, 1'b0);
    push_sym(1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Expected {d_plus, d_minus, stuffing, shift_strobe, tx_done} at cycle c
  function automatic logic [4:0] expect_at(input int c, input int nper);
    int p = c / CPB;
    int k = c % CPB;
    logic [4:0] v;
    if (p < nper) begin
      v = {sym_dp[p], sym_dm[p], sym_st[p], 1'b0, 1'b0};
      if (k == CPB - 1 && p + 1 < nper && sym_dat[p + 1]) v[1] = 1'b1;
    end else begin
      v = {1'b1, 1'b0, 1'b0, 1'b0, (c == nper * CPB)};
    end
    return v;
  endfunction

  // Sends pkt_q with EOP; optional abort or reset at a given cycle (-1 = none)
  task automatic run_packet(input string name, input int abort_at, input int rst_at);
    int nper, ncyc, idx, stop_at;
    bit pend;
    logic [4:0] obs, exp_v;
    build_model();
    nper    = sym_dp.size();
    stop_at = (abort_at >= 0) ? abort_at : rst_at;
    ncyc    = (stop_at >= 0) ? stop_at + 24 : nper * CPB + 4;
    @(negedge clk);
    tx_active = 1'b1; eop = 1'b0; serial_in = pkt_q[0];
    idx = 1; pend = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (idx < pkt_q.size()) begin serial_in = pkt_q[idx]; idx++; end
        else eop = 1'b1;
      end
      obs   = {d_plus, d_minus, stuffing, shift_strobe, tx_done};
      exp_v = (stop_at >= 0 && c > stop_at) ? 5'b10000 : expect_at(c, nper);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: dp/dm/stuff/strobe/done got %b expected %b", name, c, obs, exp_v);
      end
      if (shift_strobe) pend = 1'b1;
      if (!d_plus && !d_minus) begin tx_active = 1'b0; eop = 1'b0; end
      if (c == abort_at) tx_active = 1'b0;
      if (c == rst_at) begin
        n_rst = 1'b0; tx_active = 1'b0; eop = 1'b0;
        #1;
        obs = {d_plus, d_minus, stuffing, shift_strobe, tx_done};
        checks++;
        if (obs !== 5'b10000) begin
          errors++;
          $display("FAIL %s async_reset: dp/dm/stuff/strobe/done got %b expected 10000", name, obs);
        end
      end
    end
    n_rst = 1'b1; tx_active = 1'b0; eop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_active = 1'b0; serial_in = 1'b0; eop = 1'b0;
    #12;
    checks++;
    if ({d_plus, d_minus, stuffing, shift_strobe, tx_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_values: got %b expected 10000", {d_plus, d_minus, stuffing, shift_strobe, tx_done});
    end
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({d_plus, d_minus, stuffing, shift_strobe, tx_done} !== 5'b10000) begin
        errors++;
        $display("FAIL idle_hold: got %b expected 10000", {d_plus, d_minus, stuffing, shift_strobe, tx_done});
      end
    end
  endtask

  task automatic test_sync();
    pkt_q.delete(); push_byte(8'h80);
    run_packet("sync", -1, -1);
  endtask

  task automatic test_stuff();
    pkt_q.delete(); push_byte(8'hFF); push_byte(8'h00);
    run_packet("stuff_ff_00", -1, -1);
  endtask

  task automatic test_eop();
    pkt_q.delete(); push_byte(8'h01);
    run_packet("eop_after_01", -1, -1);
  endtask

  task automatic test_stuff_then_eop();
    pkt_q.delete();
    for (int i = 0; i < LIMIT; i++) pkt_q.push_back(1'b1);
    run_packet("stuff_before_eop", -1, -1);
  endtask

  task automatic test_abort();
    pkt_q.delete(); push_byte(8'hA5); push_byte(8'h3C);
    run_packet("abort", 6 * CPB + 3, -1);
  endtask

  task automatic test_reset_mid_eop();
    int nper;
    pkt_q.delete(); push_byte(8'h01);
    build_model();
    nper = sym_dp.size();
    run_packet("reset_in_se0", -1, (nper - 3) * CPB + 3);
    pkt_q.delete(); push_byte(8'h5A);
    run_packet("after_reset", -1, -1);
  endtask

  task automatic test_random();
    int nbytes;
    for (int p = 0; p < 5; p++) begin
      pkt_q.delete();
      nbytes = $urandom_range(1, 3);
      for (int i = 0; i < nbytes * 8; i++) pkt_q.push_back($urandom_range(0, 3) != 0);
      run_packet($sformatf("random%0d", p), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuff();
    test_eop();
    test_stuff_then_eop();
    test_abort();
    test_reset_mid_eop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
